// File: rtl/clk_pkg.sv
// clk_pkg -- shared definitions for clock-domain control blocks.
//
// Contents:
//   clk_state_e  : sequencing states of the DCM reset controller
//   clk_cnt_w()  : width of a shared down-counter able to hold the largest
//                  of three cycle-count parameters, plus one spare bit so
//                  that count-1 loads never wrap
//   CLK_CNT_W_DEFAULT : counter width for the default parameter set
package clk_pkg;

  typedef enum logic [2:0] {
    ST_RESET_DCM = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_HOLDOFF   = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAILED    = 3'd4
  } clk_state_e;

  function automatic int clk_cnt_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

  localparam int CLK_CNT_W_DEFAULT = clk_cnt_w(8, 65535, 256);

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff -- two-flop synchronizer for a single asynchronous level.
//
// Ports:
//   i_clk : destination clock
//   i_rst : synchronous active-high reset, clears both stages
//   i_d   : asynchronous input level
//   o_q   : synchronized level, two i_clk cycles of latency
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/dcm_reset_ctrl.sv
// dcm_reset_ctrl -- sequences DCM reset, lock acquisition, holdoff and
// system-reset release, with bounded retries on lock timeout.
//
// Parameters:
//   RST_CYCLES     : DCM_RST pulse length in CLOCK_13 cycles (>= 3)
//   LOCK_TIMEOUT   : cycles to wait for lock before retrying
//   HOLDOFF_CYCLES : consecutive locked cycles before SYS_RST release
//   MAX_RETRIES    : lock timeouts tolerated before FAIL (1..15)
//
// Ports:
//   CLOCK_13    in   free-running reference clock (only clock)
//   RST         in   synchronous active-high reset
//   LOCKED      in   combined DCM lock, asynchronous
//   DCM_RST     out  registered reset to the DCMs
//   SYS_RST     out  registered system reset, high in every state but RUN
//   READY       out  clocks locked and system released
//   FAIL        out  retries exhausted, sticky until RST
//   RETRY_COUNT out  timeouts since last RST or successful lock
//   LOSS_COUNT  out  lock-loss events seen in RUN (0 unless enabled)
//   o_dbg_state out  current sequencing state
//
// Build option: define DCM_RESET_CTRL_LOSS_CNT_EN to count RUN->RESET_DCM
// transitions in LOSS_COUNT (saturating at 255); otherwise it is tied to 0.
module dcm_reset_ctrl
  import clk_pkg::*;
#(
  parameter int RST_CYCLES     = 8,
  parameter int LOCK_TIMEOUT   = 65535,
  parameter int HOLDOFF_CYCLES = 256,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       CLOCK_13,
  input  logic       RST,
  input  logic       LOCKED,
  output logic       DCM_RST,
  output logic       SYS_RST,
  output logic       READY,
  output logic       FAIL,
  output logic [3:0] RETRY_COUNT,
  output logic [7:0] LOSS_COUNT,
  output clk_state_e o_dbg_state
);

  localparam int CNT_W = clk_cnt_w(RST_CYCLES, LOCK_TIMEOUT, HOLDOFF_CYCLES);

  localparam logic [CNT_W-1:0] LD_RST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_TIMEOUT = CNT_W'(LOCK_TIMEOUT - 1);
  // The cycle that moves WAIT_LOCK -> HOLDOFF has already seen lock_s=1,
  // so it counts as the first stable cycle; one fewer is left to count.
  localparam logic [CNT_W-1:0] LD_HOLDOFF =
    CNT_W'((HOLDOFF_CYCLES >= 2) ? (HOLDOFF_CYCLES - 2) : 0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [3:0]       MAX_R      = 4'(MAX_RETRIES);

  logic             w_lock_s;
  clk_state_e       r_state;
  clk_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       r_retry;
  logic [3:0]       w_retry_nxt;
  logic [3:0]       w_retry_inc;
  logic             r_dcm_rst;
  logic             r_sys_rst;
  logic             r_ready;
  logic             r_fail;

  sync_2ff u_lock_sync (
    .i_clk (CLOCK_13),
    .i_rst (RST),
    .i_d   (LOCKED),
    .o_q   (w_lock_s)
  );

  assign w_retry_inc = r_retry + 4'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_retry_nxt = r_retry;
    case (r_state)
      ST_RESET_DCM: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = LD_TIMEOUT;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      ST_WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state_nxt = ST_HOLDOFF;
          w_cnt_nxt   = LD_HOLDOFF;
        end else if (r_cnt == '0) begin
          w_retry_nxt = w_retry_inc;
          if (w_retry_inc < MAX_R) begin
            w_state_nxt = ST_RESET_DCM;
            w_cnt_nxt   = LD_RST;
          end else begin
            w_state_nxt = ST_FAILED;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      ST_HOLDOFF: begin
        if (!w_lock_s) begin
          // A glitch restarts the lock wait without re-pulsing the DCMs.
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = LD_TIMEOUT;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_RUN;
          w_retry_nxt = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      ST_RUN: begin
        if (!w_lock_s) begin
          w_state_nxt = ST_RESET_DCM;
          w_cnt_nxt   = LD_RST;
        end
      end
      ST_FAILED: begin
        w_state_nxt = ST_FAILED;
      end
      default: begin
        w_state_nxt = ST_RESET_DCM;
        w_cnt_nxt   = LD_RST;
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state register and carry no decode glitches.
  always_ff @(posedge CLOCK_13) begin
    if (RST) begin
      r_state   <= ST_RESET_DCM;
      r_cnt     <= LD_RST;
      r_retry   <= 4'd0;
      r_dcm_rst <= 1'b1;
      r_sys_rst <= 1'b1;
      r_ready   <= 1'b0;
      r_fail    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_retry   <= w_retry_nxt;
      r_dcm_rst <= (w_state_nxt == ST_RESET_DCM);
      r_sys_rst <= (w_state_nxt != ST_RUN);
      r_ready   <= (w_state_nxt == ST_RUN);
      r_fail    <= (w_state_nxt == ST_FAILED);
    end
  end

`ifdef DCM_RESET_CTRL_LOSS_CNT_EN
  logic       w_loss_evt;
  logic [7:0] r_loss_cnt;

  assign w_loss_evt = (r_state == ST_RUN) && (w_state_nxt == ST_RESET_DCM);

  always_ff @(posedge CLOCK_13) begin
    if (RST) begin
      r_loss_cnt <= 8'd0;
    end else if (w_loss_evt && (r_loss_cnt != 8'hFF)) begin
      r_loss_cnt <= r_loss_cnt + 8'd1;
    end
  end

  assign LOSS_COUNT = r_loss_cnt;
`else
  assign LOSS_COUNT = 8'd0;
`endif

  assign DCM_RST     = r_dcm_rst;
  assign SYS_RST     = r_sys_rst;
  assign READY       = r_ready;
  assign FAIL        = r_fail;
  assign RETRY_COUNT = r_retry;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dcm_reset_ctrl.sv
// tb_dcm_reset_ctrl -- directed bench for dcm_reset_ctrl with
// RST_CYCLES=4, LOCK_TIMEOUT=100, HOLDOFF_CYCLES=16, MAX_RETRIES=2.
// Inputs are driven and outputs sampled on the falling clock edge.
// Output vector layout: {DCM_RST, SYS_RST, READY, FAIL, RETRY[3:0], LOSS[7:0]}.
module tb_dcm_reset_ctrl;
  import clk_pkg::*;

  localparam int RC = 4;
  localparam int LT = 100;
  localparam int HC = 16;
  localparam int MR = 2;

`ifdef DCM_RESET_CTRL_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       dcm_rst, sys_rst, ready, fail;
  logic [3:0] retry_count;
  logic [7:0] loss_count;
  clk_state_e dbg_state;

  always #5 clk = ~clk;

  dcm_reset_ctrl #(
    .RST_CYCLES     (RC),
    .LOCK_TIMEOUT   (LT),
    .HOLDOFF_CYCLES (HC),
    .MAX_RETRIES    (MR)
  ) dut (
    .CLOCK_13    (clk),
    .RST         (rst),
    .LOCKED      (locked),
    .DCM_RST     (dcm_rst),
    .SYS_RST     (sys_rst),
    .READY       (ready),
    .FAIL        (fail),
    .RETRY_COUNT (retry_count),
    .LOSS_COUNT  (loss_count),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic        rst;
    logic        locked;
    int          cycles;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [15:0] pk(input logic d, input logic s, input logic r,
                                     input logic f, input logic [3:0] rc,
                                     input logic [7:0] lc);
    return {d, s, r, f, rc, lc};
  endfunction

  function automatic logic [7:0] exp_loss(input int n);
    if (!LOSS_EN) return 8'd0;
    if (n > 255) return 8'd255;
    return 8'(n);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_outs(input string name, input logic [15:0] exp);
    check(name, {dcm_rst, sys_rst, ready, fail, retry_count, loss_count}, exp);
  endtask

  task automatic check_state(input string name, input clk_state_e exp);
    check(name, 16'(dbg_state), 16'(exp));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench at the falling edge just after the reset edge.
  task automatic do_reset(input logic lk);
    rst    = 1'b1;
    locked = lk;
    tick(1);
    rst    = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    logic dcm_seen;
    logic prev_dcm;
    logic sys_low_seen;
    logic ready_all;

    // Basic bring-up: reset pulse, LOCKED rises after cycle 9.
    vecs[0] = '{1'b1, 1'b0, 1,  pk(1, 1, 0, 0, 4'd0, 8'd0)};  // reset edge = cycle 1
    vecs[1] = '{1'b0, 1'b0, 3,  pk(1, 1, 0, 0, 4'd0, 8'd0)};  // cycles 2..4
    vecs[2] = '{1'b0, 1'b0, 1,  pk(0, 1, 0, 0, 4'd0, 8'd0)};  // cycle 5: pulse over
    vecs[3] = '{1'b0, 1'b0, 4,  pk(0, 1, 0, 0, 4'd0, 8'd0)};  // cycles 6..9
    vecs[4] = '{1'b0, 1'b1, 17, pk(0, 1, 0, 0, 4'd0, 8'd0)};  // lock_s=1 at 11; still held at 26
    vecs[5] = '{1'b0, 1'b1, 1,  pk(0, 0, 1, 0, 4'd0, 8'd0)};  // 27 = lock_s rise + 16
    vecs[6] = '{1'b0, 1'b1, 10, pk(0, 0, 1, 0, 4'd0, 8'd0)};  // stays in RUN

    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      rst    = vecs[i].rst;
      locked = vecs[i].locked;
      tick(vecs[i].cycles);
      check_outs($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Lock loss in RUN: LOCKED low for one cycle, reaction three edges later.
    locked = 1'b0;
    tick(1);
    locked = 1'b1;
    tick(1);
    check_outs("loss_before_react", pk(0, 0, 1, 0, 4'd0, 8'd0));
    tick(1);
    check_outs("loss_react", pk(1, 1, 0, 0, 4'd0, exp_loss(1)));
    check_state("loss_state", ST_RESET_DCM);
    tick(19);
    check_outs("relock_pre", pk(0, 1, 0, 0, 4'd0, exp_loss(1)));
    tick(1);
    check_outs("relock_run", pk(0, 0, 1, 0, 4'd0, exp_loss(1)));

    // Glitch during holdoff at holdoff cycle 10: back to WAIT_LOCK, no pulse.
    do_reset(1'b1);
    tick(4);
    check_outs("glitch_waitlock", pk(0, 1, 0, 0, 4'd0, 8'd0));
    dcm_seen = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      dcm_seen |= dcm_rst;
    end
    locked = 1'b0;
    tick(1);
    dcm_seen |= dcm_rst;
    locked = 1'b1;
    tick(1);
    check_state("glitch_hold9", ST_HOLDOFF);
    tick(1);
    check_state("glitch_back", ST_WAIT_LOCK);
    for (int i = 0; i < 15; i++) begin
      dcm_seen |= dcm_rst;
      tick(1);
    end
    check("glitch_no_dcm_pulse", 16'(dcm_seen), 16'd0);
    check_outs("glitch_rerun_pre", pk(0, 1, 0, 0, 4'd0, 8'd0));
    tick(1);
    check_outs("glitch_rerun_run", pk(0, 0, 1, 0, 4'd0, 8'd0));

    // Reset during HOLDOFF, then reset held high, then a full fresh pulse.
    do_reset(1'b1);
    tick(9);
    check_state("hold_before_rst", ST_HOLDOFF);
    rst = 1'b1;
    tick(1);
    check_outs("rst_in_holdoff", pk(1, 1, 0, 0, 4'd0, 8'd0));
    check_state("rst_in_holdoff_st", ST_RESET_DCM);
    tick(20);
    check_outs("rst_held", pk(1, 1, 0, 0, 4'd0, 8'd0));
    rst    = 1'b0;
    locked = 1'b0;
    tick(3);
    check_outs("rst_release_pulse", pk(1, 1, 0, 0, 4'd0, 8'd0));
    tick(1);
    check_outs("rst_release_end", pk(0, 1, 0, 0, 4'd0, 8'd0));

    // LOCKED held low: two pulses 104 cycles apart, then FAILED.
    do_reset(1'b0);
    exp_q.push_back(16'd0);
    exp_q.push_back(16'd104);
    prev_dcm     = 1'b0;
    sys_low_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (dcm_rst && !prev_dcm) begin
        if (exp_q.size() == 0) check("dcm_rise_unexpected", 16'(i), 16'hFFFF);
        else check("dcm_rise_cycle", 16'(i), exp_q.pop_front());
      end
      prev_dcm = dcm_rst;
      sys_low_seen |= !sys_rst;
      if (i == 103) check_outs("to_before_1", pk(0, 1, 0, 0, 4'd0, 8'd0));
      if (i == 104) check_outs("to_retry_1", pk(1, 1, 0, 0, 4'd1, 8'd0));
      if (i == 207) check_outs("to_before_2", pk(0, 1, 0, 0, 4'd1, 8'd0));
      if (i == 208) check_outs("to_failed", pk(0, 1, 0, 1, 4'd2, 8'd0));
      if (i == 299) check_outs("failed_sticky", pk(0, 1, 0, 1, 4'd2, 8'd0));
      tick(1);
    end
    check("pulse_queue_empty", 16'(exp_q.size()), 16'd0);
    check("failed_sys_rst_high", 16'(sys_low_seen), 16'd0);

    // Reset while FAILED clears FAIL.
    do_reset(1'b0);
    check_outs("rst_in_failed", pk(1, 1, 0, 0, 4'd0, 8'd0));
    check_state("rst_in_failed_st", ST_RESET_DCM);

    // One timeout, then lock: RETRY_COUNT holds through holdoff, clears in RUN.
    tick(104);
    check_outs("retry_one", pk(1, 1, 0, 0, 4'd1, 8'd0));
    locked = 1'b1;
    tick(19);
    check_outs("retry_hold", pk(0, 1, 0, 0, 4'd1, 8'd0));
    tick(1);
    check_outs("retry_cleared", pk(0, 0, 1, 0, 4'd0, 8'd0));

    // 300 lock losses: LOSS_COUNT saturates at 255 when enabled.
    ready_all = 1'b1;
    for (int k = 0; k < 300; k++) begin
      locked = 1'b0;
      tick(1);
      locked = 1'b1;
      tick(22);
      ready_all &= ready;
      if (k == 253) check("loss_254", 16'(loss_count), 16'(exp_loss(254)));
      if (k == 255) check("loss_256", 16'(loss_count), 16'(exp_loss(256)));
    end
    check("loss_relock_ready", 16'(ready_all), 16'd1);
    check("loss_saturated", 16'(loss_count), 16'(exp_loss(300)));
    do_reset(1'b1);
    check_outs("loss_rst_clear", pk(1, 1, 0, 0, 4'd0, 8'd0));

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
